// File: rtl/video_checker_pkg.sv
// Shared types and the per-channel tolerance compare for the video stream checker.
package video_checker_pkg;

  localparam int unsigned CH_DEF  = 3;
  localparam int unsigned BPC_DEF = 8;
  // Widest channel the compare helper handles; narrower channels are zero-extended.
  localparam int unsigned BPC_MAX = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    FILL  = 2'd2,
    CHECK = 2'd3
  } state_t;

  typedef logic [CH_DEF*BPC_DEF-1:0] pixel_t;

  // True when |ref_c - duv_c| <= tol, computed with one extra bit of headroom.
  function automatic logic ch_within_tol(input logic [BPC_MAX-1:0] ref_c,
                                         input logic [BPC_MAX-1:0] duv_c,
                                         input logic [BPC_MAX-1:0] tol);
    logic [BPC_MAX:0] diff;
    if (ref_c >= duv_c) diff = {1'b0, ref_c} - {1'b0, duv_c};
    else                diff = {1'b0, duv_c} - {1'b0, ref_c};
    return (diff <= {1'b0, tol});
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, first-word-fall-through: pop_data_o always shows the head entry.
// The head is held in a register loaded from the array (or straight from the write
// port when the slot that becomes the head is being written in the same cycle).
module sync_fifo #(
  parameter int DEPTH = 2048,
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] rd_data_q;
  logic             do_push, do_pop;

  assign full_o     = (count_q == (AW+1)'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign do_pop     = pop_i && !empty_o;
  // A full FIFO still accepts a write when a read frees a slot in the same cycle.
  assign do_push    = push_i && (!full_o || do_pop);
  assign pop_data_o = rd_data_q;

  // Next pointer and occupancy values.
  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; flush empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array write port (no reset so it maps onto block RAM).
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data_i;
  end

  // Registered head read, forwarding the write data when it lands in the head slot.
  always_ff @(posedge clk) begin
    if (rst || flush_i)                        rd_data_q <= '0;
    else if (do_push && (wr_ptr_q == rd_ptr_d)) rd_data_q <= push_data_i;
    else                                        rd_data_q <= mem[rd_ptr_d];
  end

endmodule

// File: rtl/video_stream_checker.sv
// Loopback comparator: buffers the reference stream, aligns it to the DUV stream on
// frame start, compares pixels within a per-channel tolerance and reports per frame.
module video_stream_checker
  import video_checker_pkg::*;
#(
  parameter int CH         = 3,
  parameter int BPC        = 8,
  parameter int HRES       = 1600,
  parameter int VRES       = 900,
  parameter int FIFO_DEPTH = 2048,
  parameter int TOL        = 0,
  parameter int VS_POL     = 1,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic [CH*BPC-1:0] ref_data_i,
  input  logic              ref_dv_i,
  input  logic              ref_vs_i,
  input  logic [CH*BPC-1:0] duv_data_i,
  input  logic              duv_dv_i,
  input  logic              duv_vs_i,
  output logic              frame_done_o,
  output logic              frame_pass_o,
  output logic [CNT_W-1:0]  err_cnt_o,
  output logic [11:0]       first_err_x_o,
  output logic [11:0]       first_err_y_o,
  output logic [15:0]       frame_cnt_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam logic               VS_ACT    = (VS_POL != 0);
  localparam logic [31:0]        FRAME_PIX = 32'(HRES * VRES);
  localparam logic [11:0]        X_LAST    = 12'(HRES - 1);
  localparam logic [BPC_MAX-1:0] TOL_V     = BPC_MAX'(TOL);

  state_t state_q, state_d;

  logic ref_vs_q, duv_vs_q;
  logic ref_fs_q, duv_fs_q;

  logic              fifo_full, fifo_empty;
  logic [CH*BPC-1:0] fifo_head;
  logic              fifo_flush, push_req, pop_req, pop_ok;
  logic              push_drop, pop_under;
  logic [CH-1:0]     ch_ok;
  logic              pix_err;
  logic              frame_open, frame_close, frame_clear;

  logic [11:0]      x_q, x_d, x_b;
  logic [11:0]      y_q, y_d, y_b;
  logic [31:0]      pix_q, pix_d, pix_b;
  logic [CNT_W-1:0] err_q, err_d, err_b;
  logic             seen_q, seen_d, seen_b;
  logic [11:0]      fx_q, fx_d, fx_b;
  logic [11:0]      fy_q, fy_d, fy_b;

  // Frame-start detectors: active vsync level now, inactive on the previous cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_vs_q <= 1'b0;
      duv_vs_q <= 1'b0;
      ref_fs_q <= 1'b0;
      duv_fs_q <= 1'b0;
    end else begin
      ref_vs_q <= ref_vs_i;
      duv_vs_q <= duv_vs_i;
      ref_fs_q <= (ref_vs_i == VS_ACT) && (ref_vs_q != VS_ACT);
      duv_fs_q <= (duv_vs_i == VS_ACT) && (duv_vs_q != VS_ACT);
    end
  end

  // Next-state logic; dropping the enable returns to IDLE from anywhere.
  always_comb begin
    state_d = state_q;
    if (!en_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = ARM;
        ARM:     if (ref_fs_q) state_d = FILL;
        FILL:    if (duv_fs_q) state_d = CHECK;
        CHECK:   state_d = CHECK;
        default: state_d = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  assign fifo_flush  = !en_i || (state_q == IDLE);
  assign push_req    = en_i && ref_dv_i && ((state_q == FILL) || (state_q == CHECK));
  assign pop_req     = en_i && duv_dv_i && (state_q == CHECK);
  assign pop_ok      = pop_req && !fifo_empty;
  assign push_drop   = push_req && fifo_full && !pop_ok;
  // No bypass: a read from an empty FIFO fails even if a write arrives alongside.
  assign pop_under   = pop_req && fifo_empty;
  assign frame_open  = en_i && (state_q == FILL)  && duv_fs_q;
  assign frame_close = en_i && (state_q == CHECK) && duv_fs_q;
  assign frame_clear = fifo_flush || frame_open || frame_close;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CH*BPC)
  ) u_ref_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (fifo_flush),
    .push_i      (push_req),
    .push_data_i (ref_data_i),
    .pop_i       (pop_req),
    .pop_data_o  (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Per-channel tolerance check of the FIFO head against the incoming DUV pixel.
  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    assign ch_ok[gi] = ch_within_tol(BPC_MAX'(fifo_head[gi*BPC +: BPC]),
                                     BPC_MAX'(duv_data_i[gi*BPC +: BPC]),
                                     TOL_V);
  end

  assign pix_err = pop_req && (fifo_empty || !(&ch_ok));

  // Per-frame accounting; a pixel in the frame-start cycle already counts for the new frame.
  always_comb begin
    x_b    = x_q;
    y_b    = y_q;
    pix_b  = pix_q;
    err_b  = err_q;
    seen_b = seen_q;
    fx_b   = fx_q;
    fy_b   = fy_q;
    if (frame_clear) begin
      x_b    = '0;
      y_b    = '0;
      pix_b  = '0;
      err_b  = '0;
      seen_b = 1'b0;
      fx_b   = '0;
      fy_b   = '0;
    end
    x_d    = x_b;
    y_d    = y_b;
    pix_d  = pix_b;
    err_d  = err_b;
    seen_d = seen_b;
    fx_d   = fx_b;
    fy_d   = fy_b;
    if (pop_req) begin
      pix_d = pix_b + 32'd1;
      if (x_b == X_LAST) begin
        x_d = '0;
        y_d = y_b + 12'd1;
      end else begin
        x_d = x_b + 12'd1;
      end
      if (pix_err) begin
        if (err_b != '1) err_d = err_b + 1'b1;
        if (!seen_b) begin
          seen_d = 1'b1;
          fx_d   = x_b;
          fy_d   = y_b;
        end
      end
    end
  end

  // Per-frame registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q    <= '0;
      y_q    <= '0;
      pix_q  <= '0;
      err_q  <= '0;
      seen_q <= 1'b0;
      fx_q   <= '0;
      fy_q   <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      pix_q  <= pix_d;
      err_q  <= err_d;
      seen_q <= seen_d;
      fx_q   <= fx_d;
      fy_q   <= fy_d;
    end
  end

  // Result registers: updated at frame close, held otherwise; flags are sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_done_o  <= 1'b0;
      frame_pass_o  <= 1'b0;
      err_cnt_o     <= '0;
      first_err_x_o <= '0;
      first_err_y_o <= '0;
      frame_cnt_o   <= '0;
      overflow_o    <= 1'b0;
      underflow_o   <= 1'b0;
    end else begin
      frame_done_o <= frame_close;
      if (frame_close) begin
        err_cnt_o     <= err_q;
        first_err_x_o <= seen_q ? fx_q : 12'd0;
        first_err_y_o <= seen_q ? fy_q : 12'd0;
        frame_pass_o  <= (err_q == '0) && (pix_q == FRAME_PIX) && !overflow_o && !underflow_o;
      end
      if ((state_q == IDLE) && en_i) frame_cnt_o <= '0;
      else if (frame_close)          frame_cnt_o <= frame_cnt_o + 16'd1;
      if (push_drop) overflow_o  <= 1'b1;
      if (pop_under) underflow_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_video_stream_checker.sv
// Directed bench: a small 4x4 frame generator feeds the reference side, and a
// cycle-delay line (with optional corrupt/drop hooks) produces the DUV side.
module tb_video_stream_checker;

  logic        clk;
  logic        rst;
  logic        en_i;
  logic [23:0] ref_data_i;
  logic        ref_dv_i;
  logic        ref_vs_i;
  logic [23:0] duv_data_i;
  logic        duv_dv_i;
  logic        duv_vs_i;

  logic        frame_done_o, frame_pass_o, overflow_o, underflow_o;
  logic [31:0] err_cnt_o;
  logic [11:0] first_err_x_o, first_err_y_o;
  logic [15:0] frame_cnt_o;

  logic        t1_done, t1_pass, t1_ovf, t1_udf;
  logic [31:0] t1_err;
  logic [11:0] t1_fx, t1_fy;
  logic [15:0] t1_fcnt;

  video_stream_checker #(
    .CH(3), .BPC(8), .HRES(4), .VRES(4), .FIFO_DEPTH(8), .TOL(0), .VS_POL(1), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst), .en_i(en_i),
    .ref_data_i(ref_data_i), .ref_dv_i(ref_dv_i), .ref_vs_i(ref_vs_i),
    .duv_data_i(duv_data_i), .duv_dv_i(duv_dv_i), .duv_vs_i(duv_vs_i),
    .frame_done_o(frame_done_o), .frame_pass_o(frame_pass_o), .err_cnt_o(err_cnt_o),
    .first_err_x_o(first_err_x_o), .first_err_y_o(first_err_y_o),
    .frame_cnt_o(frame_cnt_o), .overflow_o(overflow_o), .underflow_o(underflow_o)
  );

  video_stream_checker #(
    .CH(3), .BPC(8), .HRES(4), .VRES(4), .FIFO_DEPTH(8), .TOL(1), .VS_POL(1), .CNT_W(32)
  ) dut_t1 (
    .clk(clk), .rst(rst), .en_i(en_i),
    .ref_data_i(ref_data_i), .ref_dv_i(ref_dv_i), .ref_vs_i(ref_vs_i),
    .duv_data_i(duv_data_i), .duv_dv_i(duv_dv_i), .duv_vs_i(duv_vs_i),
    .frame_done_o(t1_done), .frame_pass_o(t1_pass), .err_cnt_o(t1_err),
    .first_err_x_o(t1_fx), .first_err_y_o(t1_fy),
    .frame_cnt_o(t1_fcnt), .overflow_o(t1_ovf), .underflow_o(t1_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int done_n  = 0;
  int cyc     = 0;
  int dly     = 7;
  bit use_delay = 1'b1;
  int corr_f = -1, corr_x = -1, corr_y = -1;
  int drop_f = -1, drop_x = -1, drop_y = -1;
  int done_before;

  logic        h_vs [256];
  logic        h_dv [256];
  logic [23:0] h_d  [256];
  int          h_f  [256];
  int          h_x  [256];
  int          h_y  [256];

  always @(posedge clk) if (frame_done_o) done_n <= done_n + 1;

  function automatic logic [23:0] pix(input int f, input int x, input int y);
    return {8'(f*16 + y*4 + x), 8'(x*3 + 5), 8'(y*7 + 1)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // One clock: drive the reference side, derive the DUV side from the delay line.
  task automatic tick(input logic rvs, input logic rdv, input int f, input int x, input int y);
    int k;
    int p;
    ref_vs_i   = rvs;
    ref_dv_i   = rdv;
    ref_data_i = rdv ? pix(f, x, y) : 24'd0;
    k = cyc % 256;
    h_vs[k] = rvs; h_dv[k] = rdv; h_d[k] = ref_data_i;
    h_f[k] = f; h_x[k] = x; h_y[k] = y;
    if (use_delay) begin
      if (cyc >= dly) begin
        p = (cyc - dly) % 256;
        duv_vs_i   = h_vs[p];
        duv_dv_i   = h_dv[p];
        duv_data_i = h_d[p];
        if (h_dv[p] && h_f[p] == corr_f && h_x[p] == corr_x && h_y[p] == corr_y)
          duv_data_i = h_d[p] + 24'd1;
        if (h_dv[p] && h_f[p] == drop_f && h_x[p] == drop_x && h_y[p] == drop_y) begin
          duv_dv_i   = 1'b0;
          duv_data_i = 24'd0;
        end
      end else begin
        duv_vs_i = 1'b0; duv_dv_i = 1'b0; duv_data_i = 24'd0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 0, 0, 0);
  endtask

  // Frame: 2 vsync cycles, 2 blank, then 4 lines of 4 pixels + 2 blank (28 cycles).
  task automatic drive_frame(input int f, input int ncyc);
    for (int t = 0; t < ncyc && t < 28; t++) begin
      if (t < 2)      tick(1'b1, 1'b0, f, 0, 0);
      else if (t < 4) tick(1'b0, 1'b0, f, 0, 0);
      else if ((t - 4) % 6 < 4) tick(1'b0, 1'b1, f, (t - 4) % 6, (t - 4) / 6);
      else            tick(1'b0, 1'b0, f, 0, 0);
    end
    $display("frame %0d driven (%0d cycles, duv delay %0d)", f, ncyc, dly);
  endtask

  task automatic reset_dut();
    use_delay = 1'b1;
    en_i = 1'b0;
    rst  = 1'b1;
    idle(2);
    rst  = 1'b0;
    idle(24);
  endtask

  initial begin
    rst = 1'b1; en_i = 1'b0;
    ref_vs_i = 1'b0; ref_dv_i = 1'b0; ref_data_i = '0;
    duv_vs_i = 1'b0; duv_dv_i = 1'b0; duv_data_i = '0;
    idle(3);

    // Reset state
    check("rst_done",  32'(frame_done_o),  32'd0);
    check("rst_pass",  32'(frame_pass_o),  32'd0);
    check("rst_err",   err_cnt_o,          32'd0);
    check("rst_fx",    32'(first_err_x_o), 32'd0);
    check("rst_fy",    32'(first_err_y_o), 32'd0);
    check("rst_fcnt",  32'(frame_cnt_o),   32'd0);
    check("rst_ovf",   32'(overflow_o),    32'd0);
    check("rst_udf",   32'(underflow_o),   32'd0);

    // 1: identical stream, 7-cycle delay, 3 frames
    dly = 7;
    reset_dut();
    done_before = done_n;
    en_i = 1'b1;
    idle(3);
    drive_frame(0, 28);
    drive_frame(1, 28);
    check("t1_f0_pass", 32'(frame_pass_o), 32'd1);
    check("t1_f0_err",  err_cnt_o,         32'd0);
    check("t1_f0_fcnt", 32'(frame_cnt_o),  32'd1);
    drive_frame(2, 28);
    idle(20);
    check("t1_done_pulses", 32'(done_n - done_before), 32'd2);
    check("t1_f1_pass", 32'(frame_pass_o), 32'd1);
    check("t1_f1_err",  err_cnt_o,         32'd0);
    check("t1_fcnt",    32'(frame_cnt_o),  32'd2);
    check("t1_ovf",     32'(overflow_o),   32'd0);
    check("t1_udf",     32'(underflow_o),  32'd0);

    // 2: channel 0 of pixel (2,1) off by one
    reset_dut();
    corr_f = 0; corr_x = 2; corr_y = 1;
    en_i = 1'b1;
    idle(3);
    drive_frame(0, 28);
    drive_frame(1, 28);
    idle(10);
    check("t2_err",     err_cnt_o,          32'd1);
    check("t2_fx",      32'(first_err_x_o), 32'd2);
    check("t2_fy",      32'(first_err_y_o), 32'd1);
    check("t2_pass",    32'(frame_pass_o),  32'd0);
    check("t2_tol1_pass", 32'(t1_pass),     32'd1);
    check("t2_tol1_err",  t1_err,           32'd0);
    corr_f = -1;

    // 3: last pixel of the frame missing on the DUV side
    reset_dut();
    drop_f = 0; drop_x = 3; drop_y = 3;
    en_i = 1'b1;
    idle(3);
    drive_frame(0, 28);
    drive_frame(1, 28);
    idle(10);
    check("t3_err",  err_cnt_o,         32'd0);
    check("t3_pass", 32'(frame_pass_o), 32'd0);
    check("t3_fcnt", 32'(frame_cnt_o),  32'd1);
    drop_f = -1;

    // 4: DUV latency larger than the 8-entry reference buffer
    dly = 18;
    reset_dut();
    en_i = 1'b1;
    idle(3);
    drive_frame(0, 28);
    drive_frame(1, 28);
    check("t4_ovf_f0",  32'(overflow_o),   32'd1);
    check("t4_pass_f0", 32'(frame_pass_o), 32'd0);
    drive_frame(2, 28);
    idle(30);
    check("t4_ovf_f1",  32'(overflow_o),   32'd1);
    check("t4_pass_f1", 32'(frame_pass_o), 32'd0);
    check("t4_fcnt",    32'(frame_cnt_o),  32'd2);

    // 5: DUV frame and pixels with no reference pixels buffered
    dly = 7;
    reset_dut();
    use_delay = 1'b0;
    duv_vs_i = 1'b0; duv_dv_i = 1'b0; duv_data_i = '0;
    en_i = 1'b1;
    idle(3);
    tick(1'b1, 1'b0, 0, 0, 0);
    tick(1'b1, 1'b0, 0, 0, 0);
    idle(2);
    duv_vs_i = 1'b1; idle(2); duv_vs_i = 1'b0;
    idle(2);
    duv_dv_i = 1'b1; duv_data_i = 24'h123456; idle(3);
    duv_dv_i = 1'b0; duv_data_i = '0;
    idle(2);
    duv_vs_i = 1'b1; idle(2); duv_vs_i = 1'b0;
    idle(4);
    check("t5_udf",  32'(underflow_o),    32'd1);
    check("t5_err",  err_cnt_o,           32'd3);
    check("t5_pass", 32'(frame_pass_o),   32'd0);
    check("t5_ovf",  32'(overflow_o),     32'd0);
    check("t5_fx",   32'(first_err_x_o),  32'd0);
    check("t5_fcnt", 32'(frame_cnt_o),    32'd1);

    // 6a: reset in the middle of a frame
    reset_dut();
    en_i = 1'b1;
    idle(3);
    drive_frame(0, 28);
    drive_frame(1, 28);
    drive_frame(2, 12);
    check("t6_pre_pass", 32'(frame_pass_o), 32'd1);
    check("t6_pre_fcnt", 32'(frame_cnt_o),  32'd2);
    rst = 1'b1;
    idle(1);
    check("t6_rst_pass", 32'(frame_pass_o), 32'd0);
    check("t6_rst_fcnt", 32'(frame_cnt_o),  32'd0);
    check("t6_rst_done", 32'(frame_done_o), 32'd0);
    check("t6_rst_err",  err_cnt_o,         32'd0);
    rst = 1'b0;

    // 6b: enable dropped mid-frame, then re-armed
    reset_dut();
    en_i = 1'b1;
    idle(3);
    drive_frame(0, 28);
    drive_frame(1, 28);
    drive_frame(2, 14);
    en_i = 1'b0;
    idle(24);
    check("t6_hold_pass", 32'(frame_pass_o), 32'd1);
    check("t6_hold_fcnt", 32'(frame_cnt_o),  32'd2);
    check("t6_hold_err",  err_cnt_o,         32'd0);
    done_before = done_n;
    en_i = 1'b1;
    idle(3);
    drive_frame(3, 28);
    drive_frame(4, 28);
    drive_frame(5, 28);
    idle(20);
    check("t6_rearm_done", 32'(done_n - done_before), 32'd2);
    check("t6_rearm_pass", 32'(frame_pass_o), 32'd1);
    check("t6_rearm_fcnt", 32'(frame_cnt_o),  32'd2);
    check("t6_rearm_ovf",  32'(overflow_o),   32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
